// File: rtl/hex_arb_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
// Holds the FSM state encoding and the request vector type.
package hex_arb_pkg;

    localparam int NUM_REQ = 16;
    localparam int ID_W    = 4;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    typedef logic [NUM_REQ-1:0] req_vec_t;

endpackage

// File: rtl/onehot16_encoder.sv
// Combinational 16:4 one-hot to binary encoder.
// Each output bit is the OR of the input bits whose index has that bit set.
module onehot16_encoder
    import hex_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] onehot_i,
    output logic [ID_W-1:0]    id_o
);

    // OR together the indices of all set bits; exact for a one-hot input.
    always_comb begin
        id_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (onehot_i[i]) begin
                id_o = id_o | ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/hex_rr_arbiter.sv
// 16-requester round-robin arbiter with grant hold and release bubble.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module hex_rr_arbiter
    import hex_arb_pkg::*;
#(
    parameter int MAX_HOLD = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid,
    output logic               timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 65536) begin : g_bad_hold
        $error("hex_rr_arbiter: MAX_HOLD out of range 2..65536");
    end

    arb_state_t      state_q, state_d;
    req_vec_t        grant_q, grant_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] last_q, last_d;

    logic [ID_W-1:0] start;
    req_vec_t        rot;
    req_vec_t        pick;
    req_vec_t        win_vec;
    logic [ID_W-1:0] win_id;
    logic            release_req;

    // Rotate requests so the slot after the last winner sits at bit 0,
    // pick the lowest set bit, then rotate the pick back.
    always_comb begin
        start   = last_q + ID_W'(1);
        rot     = '0;
        win_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[start + ID_W'(i)];
        end
        pick = rot & (~rot + req_vec_t'(1));
        for (int i = 0; i < NUM_REQ; i++) begin
            win_vec[start + ID_W'(i)] = pick[i];
        end
    end

    onehot16_encoder u_enc (
        .onehot_i (win_vec),
        .id_o     (win_id)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
    logic              hold_max;

    assign hold_max = (hold_q == HOLD_W'(MAX_HOLD - 1));
`endif

    // Next-state and output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        id_d        = id_q;
        last_d      = last_q;
        release_req = done | ~req[id_q];
`ifdef ARB_TIMEOUT_EN
        hold_d      = hold_q;
        timeout_d   = 1'b0;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    state_d = ARB_GRANT;
                    grant_d = win_vec;
                    id_d    = win_id;
                    last_d  = win_id;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            ARB_GRANT: begin
`ifdef ARB_TIMEOUT_EN
                hold_d = hold_q + HOLD_W'(1);
                if (!release_req && hold_max) begin
                    release_req = 1'b1;
                    timeout_d   = 1'b1;
                end
`endif
                if (release_req) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    id_d    = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                id_d    = '0;
            end
        endcase
    end

    // State, grant and priority pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            last_q  <= 4'hF;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter and one-cycle forced-release pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant       = grant_q;
    assign grant_id    = id_q;
    assign grant_valid = (state_q == ARB_GRANT);

endmodule

// File: tb/tb_hex_rr_arbiter.sv
// Directed self-checking bench for hex_rr_arbiter.
// Define ARB_TIMEOUT_EN to also exercise the forced-release path.
module tb_hex_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [15:0] grant;
    logic [3:0]  grant_id;
    logic        grant_valid;
    logic        timeout;

    int total;
    int bad;

    hex_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        tick();
        total++;
        if ({grant, grant_id, grant_valid, timeout} !== 22'h0) begin
            bad++;
            $display("FAIL reset_outputs got g=%h id=%h v=%b t=%b want all 0",
                     grant, grant_id, grant_valid, timeout);
        end
        rst = 1'b0;
        tick();
        req = 16'h0001;
        tick();
        total++;
        if (grant !== 16'h0001 || grant_id !== 4'h0 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL single_grant got g=%h id=%h v=%b want 0001 0 1",
                     grant, grant_id, grant_valid);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        total++;
        if ({grant, grant_id, grant_valid} !== 21'h0) begin
            bad++;
            $display("FAIL done_release got g=%h id=%h v=%b want 0 0 0",
                     grant, grant_id, grant_valid);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        total++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL done_in_idle got v=%b t=%b want 0 0",
                     grant_valid, timeout);
        end
    endtask

    task automatic test_rotation();
        logic [3:0]  exp_id;
        logic [15:0] exp_g;
        do_reset();
        req = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
            exp_id = 4'(i);
            exp_g  = 16'h0001 << exp_id;
            tick();
            total++;
            if (grant_valid !== 1'b1 || grant_id !== exp_id || grant !== exp_g) begin
                bad++;
                $display("FAIL rotation[%0d] got id=%h g=%h v=%b want id=%h g=%h v=1",
                         i, grant_id, grant, grant_valid, exp_id, exp_g);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            total++;
            if (grant_valid !== 1'b0 || grant !== 16'h0) begin
                bad++;
                $display("FAIL bubble[%0d] got v=%b g=%h want 0 0000",
                         i, grant_valid, grant);
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 16'h0020;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 16'h0021;
        tick();
        total++;
        if (grant_id !== 4'h0 || grant !== 16'h0001) begin
            bad++;
            $display("FAIL wrap_first got id=%h g=%h want 0 0001", grant_id, grant);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        total++;
        if (grant_id !== 4'h5 || grant !== 16'h0020) begin
            bad++;
            $display("FAIL wrap_second got id=%h g=%h want 5 0020", grant_id, grant);
        end
        done = 1'b1;
        req  = '0;
        tick();
        done = 1'b0;
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 16'h0008;
        tick();
        req = 16'h0018;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (grant_id !== 4'h3 || grant_valid !== 1'b1) begin
                bad++;
                $display("FAIL hold_stable[%0d] got id=%h v=%b want 3 1",
                         i, grant_id, grant_valid);
            end
        end
        req = 16'h0010;
        tick();
        total++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL withdraw got v=%b t=%b want 0 0", grant_valid, timeout);
        end
        tick();
        total++;
        if (grant_id !== 4'h4 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL after_withdraw got id=%h v=%b want 4 1",
                     grant_id, grant_valid);
        end
        req = '0;
        tick();
    endtask

    task automatic test_hold();
        do_reset();
        req = 16'h0001;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (grant_valid !== 1'b1 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL to_hold[%0d] got v=%b t=%b want 1 0",
                         i, grant_valid, timeout);
            end
        end
        tick();
        total++;
        if (grant_valid !== 1'b0 || grant !== 16'h0 || timeout !== 1'b1) begin
            bad++;
            $display("FAIL to_fire got v=%b g=%h t=%b want 0 0000 1",
                     grant_valid, grant, timeout);
        end
        tick();
        total++;
        if (grant_valid !== 1'b1 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL to_regrant got v=%b t=%b want 1 0", grant_valid, timeout);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        total++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL to_done_wins got v=%b t=%b want 0 0", grant_valid, timeout);
        end
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (grant_valid !== 1'b1 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL long_hold[%0d] got v=%b t=%b want 1 0",
                         i, grant_valid, timeout);
            end
        end
`endif
        req = '0;
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 16'h0200;
        tick();
        total++;
        if (grant_id !== 4'h9 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_rst got id=%h v=%b want 9 1", grant_id, grant_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({grant, grant_id, grant_valid, timeout} !== 22'h0) begin
            bad++;
            $display("FAIL async_rst got g=%h id=%h v=%b t=%b want all 0",
                     grant, grant_id, grant_valid, timeout);
        end
        tick();
        rst = 1'b0;
        req = 16'h0600;
        tick();
        total++;
        if (grant_id !== 4'h9 || grant !== 16'h0200) begin
            bad++;
            $display("FAIL post_rst got id=%h g=%h want 9 0200", grant_id, grant);
        end
        req = '0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = '0;
        done  = 1'b0;
        test_reset();
        test_rotation();
        test_wrap();
        test_withdraw();
        test_hold();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
